// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: header field layout, invalid address, default byte width.
package router_pkg;

    localparam int         WIDTH_DEF    = 8;
    localparam int         ADDR_LSB     = 0;
    localparam int         ADDR_MSB     = 1;
    localparam int         LEN_LSB      = 2;
    localparam int         LEN_MSB      = WIDTH_DEF - 1;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    function automatic logic addr_valid(input logic [ADDR_MSB:ADDR_LSB] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running even-XOR packet parity, received parity capture and registered mismatch flag.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] acc_byte,
    input  logic             capture,
    input  logic [WIDTH-1:0] cap_byte,
    input  logic             check,
    input  logic             err_clear,
    output logic             err
);

    logic [WIDTH-1:0] int_parity;
    logic [WIDTH-1:0] pkt_parity;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity <= '0;
        end else if (clear) begin
            int_parity <= '0;
        end else if (accumulate) begin
            int_parity <= int_parity ^ acc_byte;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_parity <= '0;
        end else if (capture) begin
            pkt_parity <= cap_byte;
        end
    end

    // err stays readable until the next accepted header clears it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (check) begin
            err <= (int_parity != pkt_parity);
        end else if (err_clear) begin
            err <= 1'b0;
        end
    end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header hold, full-FIFO byte hold, dout mux and FSM steering flags.
module router_reg
    import router_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_packet_valid,
    output logic             err
);

    // No handshake: every strobe is acted on in the cycle it is seen; the FSM's busy holds the source.
    logic [WIDTH-1:0] header_byte;
    logic [WIDTH-1:0] full_byte;
    logic             hdr_capture;
    logic             acc_en;
    logic [WIDTH-1:0] acc_byte;

    assign hdr_capture = detect_add && pkt_valid && addr_valid(data_in[ADDR_MSB:ADDR_LSB]);
    // A stalled byte was already counted in LOAD_DATA; never add it again while full.
    assign acc_en      = lfd_state || (ld_state && pkt_valid && !full_state);
    assign acc_byte    = lfd_state ? header_byte : data_in;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_byte <= '0;
        end else if (hdr_capture) begin
            header_byte <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout      <= '0;
            full_byte <= '0;
        end else if (lfd_state) begin
            dout <= header_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            full_byte <= data_in;
        end else if (laf_state) begin
            dout <= full_byte;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_packet_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_packet_valid <= 1'b1;
        end else if (rst_int_reg || detect_add) begin
            low_packet_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done <= 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) || (laf_state && low_packet_valid)) begin
            parity_done <= 1'b1;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end
    end

    router_parity_chk #(.WIDTH(WIDTH)) u_parity_chk (
        .clock      (clock),
        .resetn     (resetn),
        .clear      (detect_add),
        .accumulate (acc_en),
        .acc_byte   (acc_byte),
        .capture    (ld_state && !pkt_valid),
        .cap_byte   (data_in),
        .check      (rst_int_reg),
        .err_clear  (hdr_capture),
        .err        (err)
    );

endmodule

// File: tb/tb_router_reg.sv
// Bench for router_reg: drives FSM-like strobe sequences per packet and scores dout/flags against a packet-level model.
module tb_router_reg;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         pkt_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         fifo_full = 1'b0;
    logic         detect_add = 1'b0;
    logic         lfd_state = 1'b0;
    logic         ld_state = 1'b0;
    logic         laf_state = 1'b0;
    logic         full_state = 1'b0;
    logic         rst_int_reg = 1'b0;
    logic [W-1:0] dout;
    logic         parity_done;
    logic         low_packet_valid;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] pay_q[$];
    logic         full_q[$];
    logic [W-1:0] exp_dout = '0;
    logic [W-1:0] last_hdr = '0;

    router_reg #(.WIDTH(W)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            exp_dout = e;
            check(tag, dout, e);
        end
    endtask

    // One packet through the router FSM sequence; pay_q holds payload, full_q one flag per payload byte plus parity.
    task automatic send_pkt(input logic [W-1:0] hdr, input logic [W-1:0] parity);
        logic [W-1:0] calc;
        logic [W-1:0] b;
        logic         is_par;
        int           n;
        n = pay_q.size();
        if (hdr[1:0] != 2'b11) last_hdr = hdr;
        calc = last_hdr;
        exp_q.push_back(last_hdr);
        for (int i = 0; i < n; i++) begin
            calc ^= pay_q[i];
            exp_q.push_back(pay_q[i]);
        end
        exp_q.push_back(parity);

        detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
        tick();
        detect_add = 1'b0;
        check("err_clear_on_hdr", {7'd0, err}, 8'd0);
        check("pd_clear_on_hdr", {7'd0, parity_done}, 8'd0);
        lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0;
        pop_check("dout_header");

        for (int i = 0; i <= n; i++) begin
            is_par    = (i == n);
            b         = is_par ? parity : pay_q[i];
            ld_state  = 1'b1;
            pkt_valid = !is_par;
            data_in   = b;
            fifo_full = full_q[i];
            tick();
            ld_state  = 1'b0;
            if (!full_q[i]) begin
                pop_check(is_par ? "dout_parity" : "dout_payload");
                if (is_par) check("parity_done", {7'd0, parity_done}, 8'd1);
            end else begin
                check("dout_hold_full", dout, exp_dout);
                if (is_par) check("lpv_full_parity", {7'd0, low_packet_valid}, 8'd1);
                full_state = 1'b1;
                tick();
                full_state = 1'b0;
                fifo_full  = 1'b0;
                check("dout_hold_fullst", dout, exp_dout);
                laf_state = 1'b1;
                tick();
                laf_state = 1'b0;
                pop_check(is_par ? "dout_laf_parity" : "dout_laf_payload");
                if (is_par) check("parity_done_laf", {7'd0, parity_done}, 8'd1);
            end
        end
        fifo_full = 1'b0;
        tick();
        rst_int_reg = 1'b1;
        tick();
        rst_int_reg = 1'b0;
        check("err_after_check", {7'd0, err}, {7'd0, (calc != parity)});
        check("lpv_cleared", {7'd0, low_packet_valid}, 8'd0);
        pay_q.delete();
        full_q.delete();
    endtask

    task automatic load3(input logic f0, input logic f1, input logic f2, input logic fp);
        pay_q = '{8'h11, 8'h22, 8'h33};
        full_q = '{f0, f1, f2, fp};
    endtask

    initial begin
        logic [W-1:0] hdr;
        logic [W-1:0] par;
        int           len;

        #2;
        check("rst_dout", dout, 8'd0);
        check("rst_err", {7'd0, err}, 8'd0);
        check("rst_pd", {7'd0, parity_done}, 8'd0);
        check("rst_lpv", {7'd0, low_packet_valid}, 8'd0);
        tick();
        resetn = 1'b1;
        tick();

        load3(1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h0D, 8'h0D);
        load3(1'b0, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h0D, 8'h0E);
        check("err_held", {7'd0, err}, 8'd1);

        // Invalid address: nothing captured, err not cleared, old header reappears on lfd.
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0F;
        tick();
        detect_add = 1'b0;
        check("err_kept_invalid", {7'd0, err}, 8'd1);
        lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0;
        exp_dout = 8'h0D;
        check("hdr_unchanged", dout, 8'h0D);

        pay_q = '{8'h55}; full_q = '{1'b0, 1'b0};
        send_pkt(8'h04, 8'h04 ^ 8'h55);
        load3(1'b0, 1'b1, 1'b0, 1'b0);
        send_pkt(8'h0D, 8'h0D);
        load3(1'b0, 1'b0, 1'b0, 1'b1);
        send_pkt(8'h0D, 8'h0D);

        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 6);
            hdr = {len[5:0], 2'($urandom_range(0, 2))};
            par = hdr;
            for (int i = 0; i < len; i++) begin
                pay_q.push_back(8'($urandom));
                par ^= pay_q[i];
                full_q.push_back($urandom_range(0, 3) == 0);
            end
            full_q.push_back($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) par ^= 8'(1 << $urandom_range(0, 7));
            send_pkt(hdr, par);
        end

        // Reset mid-payload must clear outputs without a clock edge.
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D;
        tick();
        detect_add = 1'b0; lfd_state = 1'b1;
        tick();
        lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'h11;
        tick();
        ld_state = 1'b0;
        check("pre_rst_dout", dout, 8'h11);
        resetn = 1'b0;
        #1;
        check("async_rst_dout", dout, 8'd0);
        check("async_rst_err", {7'd0, err}, 8'd0);
        check("async_rst_pd", {7'd0, parity_done}, 8'd0);
        check("async_rst_lpv", {7'd0, low_packet_valid}, 8'd0);
        tick();
        resetn = 1'b1;
        exp_q.delete();
        last_hdr = '0;
        exp_dout = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
